comparator_minmax_ctrl: RTL and testbench

//  Frame-based min/max tracker that time-shares ONE WIDTH-bit magnitude comparator.

---
 rtl/comparator_minmax_ctrl_pkg.sv | 17 +
 rtl/comparator_nbit.sv | 20 ++
 rtl/comparator_minmax_ctrl.sv | 125 ++++++++++++
 tb/tb_comparator_minmax_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/comparator_minmax_ctrl_pkg.sv
// Shared definitions for the min/max tracker.
//   state_t     : controller state encoding (S_IDLE=0, S_CMP_MAX=1, S_CMP_MIN=2, S_OUT=3)
//   DEF_WIDTH   : default sample width
//   DEF_CNT_W   : default frame counter width
package comparator_minmax_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CMP_MAX = 2'd1,
    S_CMP_MIN = 2'd2,
    S_OUT     = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 2;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/comparator_nbit.sv
// Unsigned WIDTH-bit magnitude comparator, purely combinational.
//   a, b    : operands
//   greater : a > b
//   less    : a < b
//   equal   : a == b
module comparator_nbit #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             greater,
  output logic             less,
  output logic             equal
);

  assign greater = (a > b);
  assign less    = (a < b);
  assign equal   = (a == b);

endmodule

// File: rtl/comparator_minmax_ctrl.sv
// Frame-based min/max tracker sharing one magnitude comparator. Each non-first
// sample is compared against the running max, then the running min, before the
// next sample is accepted. Frame results are held until the consumer takes them.
//   clk, rst             : clock, async active-high reset
//   in_valid/in_ready    : sample handshake (in_data, in_last)
//   out_valid/out_ready  : result handshake (max_val, min_val, count)
//   count                : samples in frame, saturating at 2^CNT_W-1
//
// state     | meaning
// S_IDLE    | waiting for a sample; in_ready=1
// S_CMP_MAX | latched sample vs running max
// S_CMP_MIN | latched sample vs running min
// S_OUT     | frame result held; out_valid=1
module comparator_minmax_ctrl
  import comparator_minmax_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [CNT_W-1:0] count
);

  state_t           state;
  logic             first;
  logic [WIDTH-1:0] sample;
  logic             last_q;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_gt;
  logic             cmp_lt;
  logic             cmp_eq;
  logic [CNT_W-1:0] count_inc;

  // Operands come straight from registers, so the compare settles within the
  // compare cycle and costs no extra latency.
  assign cmp_b = (state == S_CMP_MIN) ? min_val : max_val;

  comparator_nbit #(.WIDTH(WIDTH)) u_cmp (
    .a       (sample),
    .b       (cmp_b),
    .greater (cmp_gt),
    .less    (cmp_lt),
    .equal   (cmp_eq)
  );

  assign count_inc = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      first     <= 1'b1;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      max_val   <= '0;
      min_val   <= '0;
      count     <= '0;
      sample    <= '0;
      last_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (first) begin
              // First sample seeds both extremes; nothing to compare against.
              max_val <= in_data;
              min_val <= in_data;
              count   <= CNT_W'(1);
              first   <= 1'b0;
              if (in_last) begin
                state     <= S_OUT;
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
              end
            end else begin
              sample   <= in_data;
              last_q   <= in_last;
              count    <= count_inc;
              state    <= S_CMP_MAX;
              in_ready <= 1'b0;
            end
          end
        end
        S_CMP_MAX: begin
          if (cmp_gt) max_val <= sample;
          state <= S_CMP_MIN;
        end
        S_CMP_MIN: begin
          // Ties keep the existing minimum.
          if (cmp_lt && !cmp_eq) min_val <= sample;
          if (last_q) begin
            state     <= S_OUT;
            out_valid <= 1'b1;
          end else begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end
        end
        S_OUT: begin
          // count is left as-is; the next frame's first sample reloads it.
          if (out_ready) begin
            first     <= 1'b1;
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_minmax_ctrl.sv
module tb_comparator_minmax_ctrl;

  localparam int WIDTH = 2;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] min_val;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_pass   = 0;
  int q[$];

  always #5 clk = ~clk;

  comparator_minmax_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .max_val   (max_val),
    .min_val   (min_val),
    .count     (count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int model_max();
    int m = q[0];
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  function automatic int model_min();
    int m = q[0];
    foreach (q[i]) if (q[i] < m) m = q[i];
    return m;
  endfunction

  function automatic int model_cnt();
    return (q.size() > CNT_MAX) ? CNT_MAX : q.size();
  endfunction

  // Offer one sample, wait (bounded) for in_ready, return #1 after the accept edge.
  task automatic send(input int d, input bit last);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = WIDTH'(d);
    in_last  = last;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    q.push_back(d);
  endtask

  // Called right after the last sample is accepted. exp_lat = edges until out_valid.
  task automatic expect_frame(input int exp_lat, input int hold, input bit offer);
    int lat;
    int emax, emin, ecnt;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    emax = model_max();
    emin = model_min();
    ecnt = model_cnt();
    chk("latency", lat, exp_lat);
    chk("out_valid", out_valid, 1);
    chk("max", max_val, emax);
    chk("min", min_val, emin);
    chk("count", count, ecnt);
    chk("in_ready_in_out", in_ready, 0);
    if (offer) begin
      in_valid = 1'b1;
      in_data  = 2'd3;
      in_last  = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_max", max_val, emax);
      chk("hold_min", min_val, emin);
      chk("hold_count", count, ecnt);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    chk("drain_valid", out_valid, 0);
    chk("drain_ready", in_ready, 1);
    chk("count_kept", count, ecnt);
    q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int len, d;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    rst = 1'b0;

    // Reset while comparing: frame discarded, everything back to reset values.
    send(1, 0);
    send(2, 0);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_max", max_val, 0);
    chk("midrst_min", min_val, 0);
    chk("midrst_count", count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_result", out_valid, 0);

    // Mixed frame.
    send(2, 0); send(0, 0); send(3, 0); send(1, 1);
    expect_frame(2, 0, 0);

    // Single-sample frame.
    send(2, 1);
    expect_frame(0, 0, 0);

    // Ties.
    send(1, 0); send(1, 0); send(1, 1);
    expect_frame(2, 1, 0);

    // Consumer stalls with a sample offered; sample taken only after drain.
    send(0, 0); send(2, 1);
    expect_frame(2, 5, 1);
    send(3, 1);
    expect_frame(0, 0, 0);

    // Randomized frames with random consumer stalls.
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 8);
      for (int s = 0; s < len; s++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        send($urandom_range(0, 3), s == len - 1);
      end
      expect_frame((len == 1) ? 0 : 2, $urandom_range(0, 2), 1'b0);
    end

    // Counter saturation; extremes keep tracking past it.
    for (int s = 0; s < CNT_MAX; s++) begin
      d = (s == 0) ? 1 : (s == 1) ? 2 : $urandom_range(1, 2);
      send(d, 0);
    end
    chk("sat_reach", count, CNT_MAX);
    send(0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("sat_hold", count, CNT_MAX);
    chk("sat_min_upd", min_val, 0);
    send(3, 1);
    expect_frame(2, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
